// File: rtl/pulpemu_spi_cmd_frontend_if.sv
// Bus request/response bundle between SPI frontend and interconnect.
// master: frontend drives req_*, samples req_ready/rsp_*; slave: bus.
interface pulpemu_spi_cmd_frontend_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/pulpemu_spi_cmd_frontend.sv
// SPI (mode 0, single lane) to 32-bit bus request frontend.
// Ports: clk/rst, spi_clk_i/csn_i/sdi_i in, spi_sdo_o/oe_o out,
// err_o pulse, bus (master modport: req_* out, req_ready/rsp_* in).
module pulpemu_spi_cmd_frontend #(
  parameter int unsigned DUMMY_CYCLES = 32,
  parameter logic [7:0]  CMD_WR = 8'h02,
  parameter logic [7:0]  CMD_RD = 8'h0B
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk_i,
  input  logic spi_csn_i,
  input  logic spi_sdi_i,
  output logic spi_sdo_o,
  output logic spi_oe_o,
  output logic err_o,
  pulpemu_spi_cmd_frontend_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA,
    S_DUMMY, S_RDATA, S_WAIT
  } state_t;

  localparam logic [5:0] LP_DUMMY = 6'(DUMMY_CYCLES);

  state_t      r_state;
  logic [2:0]  r_clk_sync;
  logic [2:0]  r_csn_sync;
  logic [1:0]  r_sdi_sync;
  logic [5:0]  r_cnt;
  logic [30:0] r_shift;
  logic        r_we_stg;
  logic [31:0] r_addr_stg;
  logic [31:0] r_tx;
  logic        r_rd_out;
  logic        r_sdo;
  logic        r_oe;
  logic        r_err;
  logic        r_req_valid;
  logic        r_req_we;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;

  logic        w_rise;
  logic        w_fall;
  logic        w_csn_fall;
  logic        w_csn_rise;
  logic        w_sdi;
  logic [31:0] w_word;
  logic        w_busy;
  logic        w_cap;
  logic [31:0] w_tx;

  // [1] is the synchronized level, [2] its one-cycle delayed copy
  assign w_rise     = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_fall     = ~r_clk_sync[1] & r_clk_sync[2];
  assign w_csn_fall = ~r_csn_sync[1] & r_csn_sync[2];
  assign w_csn_rise = r_csn_sync[1] & ~r_csn_sync[2];
  assign w_sdi      = r_sdi_sync[1];
  assign w_word     = {r_shift, w_sdi};
  // a request accepted this cycle frees the slot
  assign w_busy     = r_req_valid & ~bus.req_ready;
  assign w_cap      = r_rd_out & bus.rsp_valid;
  assign w_tx       = w_cap ? bus.rsp_rdata : r_tx;

  assign spi_sdo_o     = r_sdo;
  assign spi_oe_o      = r_oe;
  assign err_o         = r_err;
  assign bus.req_valid = r_req_valid;
  assign bus.req_we    = r_req_we;
  assign bus.req_addr  = r_req_addr;
  assign bus.req_wdata = r_req_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_clk_sync  <= '0;
      r_csn_sync  <= '0;
      r_sdi_sync  <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_we_stg    <= 1'b0;
      r_addr_stg  <= '0;
      r_tx        <= '0;
      r_rd_out    <= 1'b0;
      r_sdo       <= 1'b0;
      r_oe        <= 1'b0;
      r_err       <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], spi_clk_i};
      r_csn_sync <= {r_csn_sync[1:0], spi_csn_i};
      r_sdi_sync <= {r_sdi_sync[0], spi_sdi_i};
      r_err      <= 1'b0;

      if (r_req_valid && bus.req_ready)
        r_req_valid <= 1'b0;

      if (w_cap) begin
        r_tx     <= bus.rsp_rdata;
        r_rd_out <= 1'b0;
      end

      // csn release beats any SPI edge in the same cycle
      if (w_csn_rise) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_oe     <= 1'b0;
        r_sdo    <= 1'b0;
        r_rd_out <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_csn_fall) begin
              r_state <= S_CMD;
              r_cnt   <= '0;
            end
          end
          S_CMD: begin
            if (w_rise) begin
              r_shift <= w_word[30:0];
              if (r_cnt == 6'd7) begin
                r_cnt <= '0;
                if (w_word[7:0] == CMD_WR) begin
                  r_we_stg <= 1'b1;
                  r_state  <= S_ADDR;
                end else if (w_word[7:0] == CMD_RD) begin
                  r_we_stg <= 1'b0;
                  r_state  <= S_ADDR;
                end else begin
                  r_err   <= 1'b1;
                  r_state <= S_WAIT;
                end
              end else begin
                r_cnt <= r_cnt + 6'd1;
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              r_shift <= w_word[30:0];
              if (r_cnt == 6'd31) begin
                r_cnt <= '0;
                if (r_we_stg) begin
                  r_addr_stg <= w_word;
                  r_state    <= S_WDATA;
                end else if (w_busy) begin
                  r_err   <= 1'b1;
                  r_state <= S_WAIT;
                end else begin
                  r_req_valid <= 1'b1;
                  r_req_we    <= 1'b0;
                  r_req_addr  <= w_word;
                  r_req_wdata <= '0;
                  r_rd_out    <= 1'b1;
                  r_state     <= S_DUMMY;
                end
              end else begin
                r_cnt <= r_cnt + 6'd1;
              end
            end
          end
          S_WDATA: begin
            if (w_rise) begin
              r_shift <= w_word[30:0];
              if (r_cnt == 6'd31) begin
                r_cnt   <= '0;
                r_state <= S_WAIT;
                if (w_busy) begin
                  r_err <= 1'b1;
                end else begin
                  r_req_valid <= 1'b1;
                  r_req_we    <= 1'b1;
                  r_req_addr  <= r_addr_stg;
                  r_req_wdata <= w_word;
                end
              end else begin
                r_cnt <= r_cnt + 6'd1;
              end
            end
          end
          S_DUMMY: begin
            // first fall seen is the tail of the last address clock
            if (w_fall) begin
              if (r_cnt == LP_DUMMY) begin
                r_cnt    <= '0;
                r_state  <= S_RDATA;
                r_oe     <= 1'b1;
                r_rd_out <= 1'b0;
                if (r_rd_out && !bus.rsp_valid) begin
                  r_tx  <= '0;
                  r_sdo <= 1'b0;
                  r_err <= 1'b1;
                end else begin
                  r_tx  <= w_tx;
                  r_sdo <= w_tx[31];
                end
              end else begin
                r_cnt <= r_cnt + 6'd1;
              end
            end
          end
          S_RDATA: begin
            if (w_fall) begin
              if (r_cnt == 6'd31) begin
                r_cnt   <= '0;
                r_state <= S_WAIT;
                r_oe    <= 1'b0;
                r_sdo   <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 6'd1;
                r_tx  <= {r_tx[30:0], 1'b0};
                r_sdo <= r_tx[30];
              end
            end
          end
          S_WAIT: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulpemu_spi_cmd_frontend.sv
// Directed bench for pulpemu_spi_cmd_frontend with a frame-level model.
// Drives SPI frames, acts as bus slave, checks requests/sdo/err.
module tb_pulpemu_spi_cmd_frontend;

  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] CMD_RD = 8'h0B;
  localparam int H = 8;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk;
  logic rst;
  logic spi_clk;
  logic spi_csn;
  logic spi_sdi;
  logic spi_sdo;
  logic spi_oe;
  logic err;

  pulpemu_spi_cmd_frontend_if bus_if();

  pulpemu_spi_cmd_frontend #(
    .DUMMY_CYCLES(32),
    .CMD_WR(CMD_WR),
    .CMD_RD(CMD_RD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi_clk_i(spi_clk),
    .spi_csn_i(spi_csn),
    .spi_sdi_i(spi_sdi),
    .spi_sdo_o(spi_sdo),
    .spi_oe_o(spi_oe),
    .err_o(err),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int obs_err = 0;
  int exp_err = 0;
  int n_acc = 0;
  int rd_acc = 0;
  int rsp_delay = 0;
  logic [31:0] rsp_data = '0;
  logic [31:0] exp_word = '0;
  req_t exp_q[$];
  logic g_oe_any;
  logic g_sdo_any;
  logic g_last_sdo;
  logic g_last_oe;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // frame-level model: what one complete SPI frame must produce
  task automatic model_frame(input logic [7:0] cmd,
                             input logic [31:0] a,
                             input logic [31:0] d,
                             input bit rsp_ok,
                             input logic [31:0] rd);
    req_t r;
    if (cmd == CMD_WR) begin
      r.we = 1'b1; r.addr = a; r.wdata = d;
      exp_q.push_back(r);
    end else if (cmd == CMD_RD) begin
      r.we = 1'b0; r.addr = a; r.wdata = '0;
      exp_q.push_back(r);
      exp_word = rsp_ok ? rd : 32'h0;
      if (!rsp_ok) exp_err++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic spi_bit(input logic mosi);
    spi_sdi = mosi;
    repeat (H) @(negedge clk);
    g_last_sdo = spi_sdo;
    g_last_oe  = spi_oe;
    g_oe_any   = g_oe_any | spi_oe;
    g_sdo_any  = g_sdo_any | spi_sdo;
    spi_clk = 1'b1;
    repeat (H) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic csn_low();
    g_oe_any  = 1'b0;
    g_sdo_any = 1'b0;
    spi_csn = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic csn_high();
    repeat (H) @(negedge clk);
    spi_csn = 1'b1;
    repeat (4 * H) @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] c, input logic [31:0] a,
                          input logic [31:0] d);
    csn_low();
    send_bits({24'h0, c}, 8);
    send_bits(a, 32);
    send_bits(d, 32);
    csn_high();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] w,
                         output int oe_ones, output logic oe_pre);
    w = '0;
    oe_ones = 0;
    csn_low();
    send_bits({24'h0, CMD_RD}, 8);
    send_bits(a, 32);
    send_bits(32'h0, 32);
    oe_pre = g_oe_any;
    for (int i = 0; i < 32; i++) begin
      spi_bit(1'b0);
      w = {w[30:0], g_last_sdo};
      if (g_last_oe === 1'b1) oe_ones++;
    end
    csn_high();
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // compare process: request handshake, stability, err pulses
  initial begin : mon
    logic        held_v;
    logic        held_we;
    logic [31:0] held_a;
    logic [31:0] held_d;
    req_t        e;
    held_v = 1'b0;
    held_we = 1'b0;
    held_a = '0;
    held_d = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst !== 1'b0) begin
        held_v = 1'b0;
      end else begin
        if (err === 1'b1) obs_err++;
        if (bus_if.req_valid === 1'b1) begin
          if (held_v) begin
            chk("req_stable_addr", bus_if.req_addr, held_a);
            chk("req_stable_we", {31'h0, bus_if.req_we}, {31'h0, held_we});
            if (held_we)
              chk("req_stable_wdata", bus_if.req_wdata, held_d);
          end else if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_req: got addr %h expected no request",
                     bus_if.req_addr);
          end
          held_v  = 1'b1;
          held_we = bus_if.req_we;
          held_a  = bus_if.req_addr;
          held_d  = bus_if.req_wdata;
          if (bus_if.req_ready === 1'b1) begin
            held_v = 1'b0;
            n_acc++;
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("req_we", {31'h0, bus_if.req_we}, {31'h0, e.we});
              chk("req_addr", bus_if.req_addr, e.addr);
              if (e.we) chk("req_wdata", bus_if.req_wdata, e.wdata);
              else rd_acc++;
            end
          end
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  // bus slave: one response per accepted read, rsp_delay cycles later
  initial begin : resp
    int seen;
    int timer;
    seen = 0;
    timer = 0;
    bus_if.rsp_valid = 1'b0;
    bus_if.rsp_rdata = '0;
    forever begin
      @(negedge clk);
      bus_if.rsp_valid = 1'b0;
      if (rd_acc != seen) begin
        seen = rd_acc;
        timer = rsp_delay;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          bus_if.rsp_valid = 1'b1;
          bus_if.rsp_rdata = rsp_data;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] w;
    int          ones;
    logic        pre;
    int          acc0;
    rst = 1'b1;
    spi_clk = 1'b0;
    spi_csn = 1'b1;
    spi_sdi = 1'b0;
    bus_if.req_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_sdo", {31'h0, spi_sdo}, 32'h0);
    chk("rst_oe", {31'h0, spi_oe}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_req_valid", {31'h0, bus_if.req_valid}, 32'h0);
    chk("rst_req_we", {31'h0, bus_if.req_we}, 32'h0);
    chk("rst_req_addr", bus_if.req_addr, 32'h0);
    chk("rst_req_wdata", bus_if.req_wdata, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1: plain write
    model_frame(CMD_WR, 32'h1C000000, 32'hDEADBEEF, 1'b0, '0);
    do_write(CMD_WR, 32'h1C000000, 32'hDEADBEEF);
    wait_drain("t1_drain");
    chk("t1_err", obs_err, exp_err);
    chk("t1_oe", {31'h0, g_oe_any}, 32'h0);

    // 2: read, response 5 clk after accept
    rsp_delay = 5;
    rsp_data = 32'h12345678;
    model_frame(CMD_RD, 32'h1A100004, '0, 1'b1, 32'h12345678);
    do_read(32'h1A100004, w, ones, pre);
    chk("t2_word", w, exp_word);
    chk("t2_word_lit", w, 32'h12345678);
    chk("t2_oe_ones", ones, 32);
    chk("t2_oe_pre", {31'h0, pre}, 32'h0);
    chk("t2_oe_after", {31'h0, spi_oe}, 32'h0);
    chk("t2_err", obs_err, exp_err);
    wait_drain("t2_drain");

    // 3: response arrives after the dummy window
    rsp_delay = 700;
    rsp_data = 32'hCAFEF00D;
    model_frame(CMD_RD, 32'h1A100008, '0, 1'b0, '0);
    do_read(32'h1A100008, w, ones, pre);
    chk("t3_word", w, exp_word);
    chk("t3_word_lit", w, 32'h0);
    chk("t3_oe_ones", ones, 32);
    chk("t3_err", obs_err, exp_err);
    wait_drain("t3_drain");

    // 4: bad command
    acc0 = n_acc;
    model_frame(8'hFF, '0, '0, 1'b0, '0);
    csn_low();
    send_bits(32'hFF, 8);
    repeat (6) @(negedge clk);
    chk("t4_err_after_cmd", obs_err, exp_err);
    send_bits(32'hA5A5, 16);
    csn_high();
    chk("t4_oe", {31'h0, g_oe_any}, 32'h0);
    chk("t4_sdo", {31'h0, g_sdo_any}, 32'h0);
    chk("t4_noreq", n_acc, acc0);
    chk("t4_err", obs_err, exp_err);

    // 5: write stalled by bus, csn released, then accepted
    bus_if.req_ready = 1'b0;
    acc0 = n_acc;
    model_frame(CMD_WR, 32'h1C000010, 32'h0BADF00D, 1'b0, '0);
    do_write(CMD_WR, 32'h1C000010, 32'h0BADF00D);
    repeat (100) @(negedge clk);
    chk("t5_held", {31'h0, bus_if.req_valid}, 32'h1);
    bus_if.req_ready = 1'b1;
    wait_drain("t5_drain");
    repeat (5) @(negedge clk);
    chk("t5_once", n_acc - acc0, 1);
    chk("t5_dropped", {31'h0, bus_if.req_valid}, 32'h0);
    chk("t5_err", obs_err, exp_err);

    // 6: reset mid address, then a fresh frame
    acc0 = n_acc;
    csn_low();
    send_bits({24'h0, CMD_WR}, 8);
    send_bits(32'h1C000, 12);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_bits(32'h12345, 20);
    send_bits(32'h55AA55AA, 32);
    csn_high();
    repeat (20) @(negedge clk);
    chk("t6_lost", n_acc, acc0);
    model_frame(CMD_WR, 32'h00001230, 32'hA5A55A5A, 1'b0, '0);
    do_write(CMD_WR, 32'h00001230, 32'hA5A55A5A);
    wait_drain("t6_drain");
    chk("t6_err", obs_err, exp_err);

    chk("lit_acc", n_acc, 5);
    chk("lit_err", obs_err, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
